cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter
Interface
REQ-001 clk  in  1  clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ic_rd_req  in  1  icache line-read request; held until ic_rd_rdy.
REQ-004 ic_rd_addr  in  32  icache line address; [3:0] ignored.
REQ-005 ic_rd_rdy  out  1  icache request accepted (1-cycle pulse).
REQ-006 ic_ret_valid  out  1  beat on mem_ret_data belongs to icache.
REQ-007 ic_ret_last  out  1  final icache beat.
REQ-008 dc_rd_req  in  1  dcache line-read request; held until dc_rd_rdy.
REQ-009 dc_rd_addr  in  32  dcache line address; [3:0] ignored.
REQ-010 dc_rd_rdy  out  1  dcache request accepted (1-cycle pulse).
REQ-011 dc_ret_valid  out  1  beat on mem_ret_data belongs to dcache.
REQ-012 dc_ret_last  out  1  final dcache beat.
REQ-013 dc_wr_req  in  1  dcache dirty-line write-back request.
REQ-014 dc_wr_addr  in  32  write-back line address.
REQ-015 dc_wr_data  in  128  write-back line data, word 0 in [31:0].
REQ-016 dc_wr_rdy  out  1  write buffer empty; dc_wr_req accepted when both high.
REQ-017 mem_rd_req  out  1  line-read request to memory bridge.
REQ-018 mem_rd_addr  out  32  granted line address, [3:0]=0.
REQ-019 mem_rd_rdy  in  1  bridge accepts mem_rd_req.
REQ-020 mem_ret_valid  in  1  read-return beat valid; data wired directly to both caches.
REQ-021 mem_ret_last  in  1  final beat of 4-beat burst.
REQ-022 mem_wr_req  out  1  line-write request to bridge.
REQ-023 mem_wr_addr  out  32  buffered write address, [3:0]=0.
REQ-024 mem_wr_data  out  128  buffered write data.
REQ-025 mem_wr_rdy  in  1  bridge accepts mem_wr_req.
Function
REQ-026 Read FSM states R_IDLE, R_REQ, R_DATA; exactly one read is outstanding at a time.
REQ-027 R_IDLE: when any eligible rd_req is high, latch owner and addr, go to R_REQ next cycle; with no eligible request, stay.
REQ-028 When both caches are eligible, grant the cache that did not win the previous grant; the last-grant pointer resets to dcache, so icache wins the first tie.
REQ-029 A read is ineligible while the write buffer is valid with the same addr[31:4], or while a write is being captured that cycle with the same addr[31:4]; it waits until the buffer drains.
REQ-030 R_REQ: mem_rd_req=1 and mem_rd_addr=latched addr; owner rd_rdy=mem_rd_rdy (combinational); on mem_rd_rdy go to R_DATA.
REQ-031 R_DATA: owner ret_valid=mem_ret_valid and owner ret_last=mem_ret_last; non-owner outputs are 0; on mem_ret_valid & mem_ret_last go to R_IDLE.
REQ-032 mem_ret_valid outside R_DATA is ignored; no ret_valid is asserted.
REQ-033 Minimum read latency: request seen in R_IDLE at cycle N gives mem_rd_req at N+1.
REQ-034 Write buffer holds one entry; dc_wr_rdy = ~wb_valid; dc_wr_req & dc_wr_rdy captures addr/data and sets wb_valid next cycle.
REQ-035 mem_wr_req = wb_valid; mem_wr_rdy & wb_valid clears wb_valid; no capture happens in the same cycle (dc_wr_rdy low).
REQ-036 The read and write paths run concurrently; the write does not block unrelated reads.
Reset
REQ-037 With rst high: FSM goes to R_IDLE, wb_valid=0, last-grant=dcache, and all outputs are 0 (dc_wr_rdy becomes 1 the cycle after rst drops); an in-flight burst is abandoned and its later beats are ignored.
Structure
REQ-038 Package cache_arb_pkg holds read-FSM state encoding, LINE_OFF_W=4, and line type constant 3'b100.
REQ-039 One sub-module, cache_wr_buf, implements the one-entry write buffer (REQ-034/035).
Verification
REQ-040 Both caches issue a read in the same cycle, ic 0x1000 and dc 0x2000: icache granted first with mem_rd_addr=0x1000, then dcache 0x2000 after ic's ret_last.
REQ-041 dc write to 0x3000 is buffered and mem_wr_rdy is held low; dc read 0x3004: no mem_rd_req until mem_wr_rdy is pulsed, then mem_rd_addr=0x3000.
REQ-042 Burst of 4 beats 0xA0..0xA3 for the icache owner: ic_ret_valid on 4 cycles, ic_ret_last only with 0xA3, dc_ret_valid stays 0.
REQ-043 mem_rd_rdy held low 5 cycles: mem_rd_req and addr stay stable and ic_rd_rdy pulses once.
REQ-044 rst asserted mid-burst after beat 2: outputs 0, later beats ignored, and a new dc read at 0x4000 is granted normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and line-geometry helpers for the cache/memory arbiter.
// Imported by the arbiter top and its write buffer.
package cache_arb_pkg;

    // Line size code is log2 of the line length in bytes (16-byte lines).
    localparam logic [2:0]  LINE_TYPE  = 3'b100;
    localparam int          LINE_OFF_W = int'(LINE_TYPE);
    localparam logic [31:0] LINE_MASK  = ~((32'd1 << LINE_OFF_W) - 32'd1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & LINE_MASK;
    endfunction

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & LINE_MASK) == 32'd0;
    endfunction

endpackage

// File: rtl/cache_wr_buf.sv
// One-entry dcache write-back buffer: captures a dirty line when empty and
// presents it to the memory bridge until accepted.
module cache_wr_buf
    import cache_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_req,
    input  logic [31:0]  wr_addr,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         buf_valid,
    output logic [31:0]  buf_addr,
    output logic [127:0] buf_data,
    input  logic         mem_wr_rdy
);

    assign wr_rdy = ~buf_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (wr_req && wr_rdy) begin
            buf_valid <= 1'b1;
        end else if (mem_wr_rdy && buf_valid) begin
            buf_valid <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; buf_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_req && wr_rdy) begin
            buf_addr <= line_addr(wr_addr);
            buf_data <= wr_data;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line reads onto one memory read channel (one read
// outstanding) and forwards dcache write-backs through a one-entry buffer.
module cache_mem_arbiter
    import cache_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ic_rd_req,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic         ic_ret_last,
    input  logic         dc_rd_req,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic         dc_ret_last,
    input  logic         dc_wr_req,
    input  logic [31:0]  dc_wr_addr,
    input  logic [127:0] dc_wr_data,
    output logic         dc_wr_rdy,
    output logic         mem_rd_req,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_rdy,
    input  logic         mem_ret_valid,
    input  logic         mem_ret_last,
    output logic         mem_wr_req,
    output logic [31:0]  mem_wr_addr,
    output logic [127:0] mem_wr_data,
    input  logic         mem_wr_rdy
);

    rd_state_t    state_q, state_d;
    owner_t       owner_q, last_grant_q, grant_owner;
    logic [31:0]  rd_addr_q;
    logic         wb_rdy, wb_valid, wb_cap;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         ic_hit, dc_hit, ic_elig, dc_elig, grant_any;

    cache_wr_buf u_wr_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (dc_wr_req),
        .wr_addr    (dc_wr_addr),
        .wr_data    (dc_wr_data),
        .wr_rdy     (wb_rdy),
        .buf_valid  (wb_valid),
        .buf_addr   (wb_addr),
        .buf_data   (wb_data),
        .mem_wr_rdy (mem_wr_rdy)
    );

    // A read may not overtake a write-back to the same line, buffered or arriving now.
    assign wb_cap  = dc_wr_req & wb_rdy;
    assign ic_hit  = (wb_valid & same_line(ic_rd_addr, wb_addr)) |
                     (wb_cap & same_line(ic_rd_addr, dc_wr_addr));
    assign dc_hit  = (wb_valid & same_line(dc_rd_addr, wb_addr)) |
                     (wb_cap & same_line(dc_rd_addr, dc_wr_addr));
    assign ic_elig = ic_rd_req & ~ic_hit;
    assign dc_elig = dc_rd_req & ~dc_hit;
    assign grant_any   = ic_elig | dc_elig;
    assign grant_owner = (dc_elig && (!ic_elig || last_grant_q == OWN_IC)) ? OWN_DC : OWN_IC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_DC;
        end else if (state_q == R_IDLE && grant_any) begin
            owner_q      <= grant_owner;
            rd_addr_q    <= line_addr(grant_owner == OWN_DC ? dc_rd_addr : ic_rd_addr);
            last_grant_q <= grant_owner;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (grant_any) state_d = R_REQ;
            R_REQ:   if (mem_rd_rdy) state_d = R_DATA;
            R_DATA:  if (mem_ret_valid && mem_ret_last) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ic_rd_rdy    = 1'b0;
        ic_ret_valid = 1'b0;
        ic_ret_last  = 1'b0;
        dc_rd_rdy    = 1'b0;
        dc_ret_valid = 1'b0;
        dc_ret_last  = 1'b0;
        dc_wr_rdy    = 1'b0;
        mem_rd_req   = 1'b0;
        mem_rd_addr  = 32'd0;
        mem_wr_req   = 1'b0;
        mem_wr_addr  = 32'd0;
        mem_wr_data  = 128'd0;
        // Everything is held at zero while rst is high, including dc_wr_rdy.
        if (!rst) begin
            dc_wr_rdy  = wb_rdy;
            mem_wr_req = wb_valid;
            if (wb_valid) begin
                mem_wr_addr = wb_addr;
                mem_wr_data = wb_data;
            end
            case (state_q)
                R_REQ: begin
                    mem_rd_req  = 1'b1;
                    mem_rd_addr = rd_addr_q;
                    if (owner_q == OWN_DC) dc_rd_rdy = mem_rd_rdy;
                    else                   ic_rd_rdy = mem_rd_rdy;
                end
                R_DATA: begin
                    if (owner_q == OWN_DC) begin
                        dc_ret_valid = mem_ret_valid;
                        dc_ret_last  = mem_ret_last;
                    end else begin
                        ic_ret_valid = mem_ret_valid;
                        ic_ret_last  = mem_ret_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
